// File: rtl/fc_pkg.sv
// fc_pkg: shared FSM state type and width helpers for the FC pipeline stages.
package fc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} fc_state_t;
  function automatic int fc_ew(input int n, input int k);
    return 2 * n + k - 2;
  endfunction
  function automatic int fc_iw(input int j);
    return (j <= 1) ? 1 : $clog2(j);
  endfunction
endpackage

// File: rtl/fc_max_sel.sv
// fc_max_sel: strict-greater compare-select, so ties keep the earlier index.
module fc_max_sel #(
  parameter int EW = 17,
  parameter int IW = 2
) (
  input  logic [EW-1:0] best_val,
  input  logic [IW-1:0] best_idx,
  input  logic [EW-1:0] cand_val,
  input  logic [IW-1:0] cand_idx,
  output logic [EW-1:0] next_val,
  output logic [IW-1:0] next_idx
);
  logic w_take;
  always_comb begin
    w_take   = cand_val > best_val;
    next_val = w_take ? cand_val : best_val;
    next_idx = w_take ? cand_idx : best_idx;
  end
endmodule

// File: rtl/fc_argmax_seq.sv
// fc_argmax_seq: sequential argmax over a latched J-element ReLU vector, one element per cycle.
module fc_argmax_seq
  import fc_pkg::*;
#(
  parameter int N = 8,
  parameter int J = 3,
  parameter int K = 3,
  localparam int EW = fc_ew(N, K),
  localparam int IW = fc_iw(J)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [J*EW-1:0] in_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic [EW-1:0] out_max,
  output logic          out_zero
);
  fc_state_t       r_state;
  logic [J*EW-1:0] r_vec;
  logic [IW-1:0]   r_cnt;
  logic [IW-1:0]   r_best_idx;
  logic [EW-1:0]   r_best_val;
  logic            r_zero;
  logic [EW-1:0]   w_cand;
  logic [EW-1:0]   w_next_val;
  logic [IW-1:0]   w_next_idx;
  assign w_cand = r_vec[r_cnt*EW +: EW];
  fc_max_sel #(.EW(EW), .IW(IW)) u_sel (
    .best_val(r_best_val),
    .best_idx(r_best_idx),
    .cand_val(w_cand),
    .cand_idx(r_cnt),
    .next_val(w_next_val),
    .next_idx(w_next_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vec      <= '0;
      r_cnt      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
      r_zero     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_vec      <= in_vec;
          r_best_idx <= '0;
          r_best_val <= in_vec[EW-1:0];
          r_zero     <= in_vec[EW-1:0] == '0;
          r_cnt      <= IW'(1);
          r_state    <= (J == 1) ? DONE : SCAN;
        end
        SCAN: begin
          r_best_idx <= w_next_idx;
          r_best_val <= w_next_val;
          r_zero     <= w_next_val == '0;
          r_cnt      <= r_cnt + IW'(1);
          if (r_cnt == IW'(J - 1)) r_state <= DONE;
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign out_idx   = r_best_idx;
  assign out_max   = r_best_val;
  assign out_zero  = r_zero;
endmodule

// File: tb/tb_fc_argmax_seq.sv
// tb_fc_argmax_seq: directed and random argmax vectors checked against a plain-loop reference.
module tb_fc_argmax_seq;
  import fc_pkg::*;
  localparam int J  = 3;
  localparam int EW = fc_ew(8, 3);
  localparam int IW = fc_iw(J);
  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0;
  logic          in_ready;
  logic [J*EW-1:0] in_vec = '0;
  logic          out_valid;
  logic          out_ready = 0;
  logic [IW-1:0] out_idx;
  logic [EW-1:0] out_max;
  logic          out_zero;
  int total = 0;
  int bad = 0;
  fc_argmax_seq #(.N(8), .J(J), .K(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_max(out_max),
    .out_zero(out_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic [J*EW-1:0] pack3(input int a, input int b, input int c);
    logic [EW-1:0] ea, eb, ec;
    ea = EW'(a);
    eb = EW'(b);
    ec = EW'(c);
    return {ec, eb, ea};
  endfunction
  task automatic send(input logic [J*EW-1:0] v, input logic [J*EW-1:0] junk, input int hold);
    int ei, lat;
    logic [EW-1:0] em, e;
    ei = 0;
    em = v[EW-1:0];
    for (int j = 1; j < J; j++) begin
      e = v[j*EW +: EW];
      if (e > em) begin
        em = e;
        ei = j;
      end
    end
    chk("ready_before", 32'(in_ready), 1);
    in_valid = 1;
    in_vec   = v;
    @(negedge clk);
    in_valid = 0;
    in_vec   = junk;
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("ready_busy", 32'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), J);
    for (int h = 0; h <= hold; h++) begin
      chk("valid", 32'(out_valid), 1);
      chk("ready_done", 32'(in_ready), 0);
      chk("idx", 32'(out_idx), 32'(ei));
      chk("max", 32'(out_max), 32'(em));
      chk("zero", 32'(out_zero), 32'(em == 0));
      if (h < hold) @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("valid_after_hs", 32'(out_valid), 0);
    chk("ready_after_hs", 32'(in_ready), 1);
  endtask
  initial begin
    logic [J*EW-1:0] v;
    int mode;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_max", 32'(out_max), 0);
    chk("rst_zero", 32'(out_zero), 1);
    rst = 0;
    @(negedge clk);
    send(pack3(16, 0, 0), '0, 0);
    send(pack3(5, 9, 9), '0, 0);
    send(pack3(0, 0, 0), '0, 0);
    send(pack3(1, 2, 131071), '0, 4);
    send(pack3(7, 4, 1), pack3(0, 0, 99), 0);
    in_valid = 1;
    in_vec   = pack3(9, 12, 15);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_ready", 32'(in_ready), 1);
      @(negedge clk);
    end
    chk("abort_idx", 32'(out_idx), 0);
    chk("abort_max", 32'(out_max), 0);
    chk("abort_zero", 32'(out_zero), 1);
    send(pack3(3, 1, 2), '0, 0);
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(0, 1);
      v = (mode == 0) ? pack3($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3))
                      : pack3($urandom_range(0, 131071), $urandom_range(0, 131071), $urandom_range(0, 131071));
      send(v, pack3($urandom_range(0, 131071), $urandom_range(0, 131071), $urandom_range(0, 131071)),
           $urandom_range(0, 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
